home_broadcast_sequencer: RTL
=============================

Name: home_broadcast_sequencer

Overview:
- Drives the home-cell position memory read port and produces the aligned broadcast sideband consumed by the reference-data extractor and the filter bank: particle_id, ref_id, phase, prev_phase, reading_particle_num.
- Per run, reads the particle count from address 0.
- For each reference particle, sweeps the home-cell particles once, then toggles phase and advances ref_id.

Parameters:
- PARTICLE_ID_WIDTH, 7, width of particle IDs, memory addresses and the count.
- MEM_RD_LAT, 1, home-cell memory read latency in cycles, from rd_en/rd_addr to data; must be >= 1.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- start  in  1  pulse; begins a run when in IDLE
- stall  in  1  downstream backpressure; suppresses issuing new reads
- rd_count  in  PARTICLE_ID_WIDTH  low bits of the memory x-word; valid when reading_particle_num=1
- rd_en  out  1  memory read enable
- rd_addr  out  PARTICLE_ID_WIDTH  memory read address
- data_valid  out  1  memory output carries a particle this cycle
- particle_id  out  PARTICLE_ID_WIDTH  ID of the particle on the memory output
- ref_id  out  PARTICLE_ID_WIDTH  current reference ID, aligned with the data
- phase  out  1  reference parity, aligned with the data
- prev_phase  out  1  phase delayed by one cycle
- reading_particle_num  out  1  memory output carries the count word
- ref_particle_count  out  PARTICLE_ID_WIDTH  captured count
- busy  out  1  run in progress
- done  out  1  one-cycle pulse at the end of a run

Behaviour:
- Reset: clk, rst synchronous active-high. All outputs are 0, except ref_id=1. FSM goes to IDLE. The latency delay line is flushed (valid bits cleared). Reset mid-run aborts with no done pulse.
- FSM states:
  - IDLE: on start, issue rd_en=1, rd_addr=0 and go to NUM_WAIT; set busy=1. start is ignored outside IDLE.
  - NUM_WAIT: wait MEM_RD_LAT cycles. reading_particle_num=1 for exactly the cycle the count word emerges; ref_particle_count <= rd_count that cycle.
    - count=0: go to FINISH.
    - otherwise: ref_id=1, phase=0, go to SWEEP.
  - SWEEP: each cycle with stall=0, issue rd_en=1 at the current address, then increment it. The address starts at 1 (see Optional Feature). With stall=1, rd_en=0 and the address holds. After issuing address N (N = count), go to SWITCH.
  - SWITCH: one cycle, rd_en=0.
    - ref_id=N: go to DRAIN.
    - otherwise: ref_id+1, phase toggles, go to SWEEP.
  - DRAIN: wait until the delay line is empty (MEM_RD_LAT cycles), then go to FINISH.
  - FINISH: done=1 for one cycle, busy=0, go to IDLE. ref_id and phase hold their last values until the next start.
- Alignment:
  - data_valid, particle_id, ref_id and phase are the issue-side values (rd_en, rd_addr, ref counter, phase bit) delayed by exactly MEM_RD_LAT cycles through a shift register.
  - The shift register always advances; stall only creates bubbles (data_valid=0).
  - prev_phase is the phase output registered one more cycle.
- Boundaries:
  - N=1: one sweep of one particle, no phase toggle.
  - N=127 (max): addresses 1..127, no wrap; address arithmetic never exceeds N.
  - stall asserted in the same cycle as the final issue: the issue is suppressed and the final address is reissued later.
  - stall during SWITCH/DRAIN/NUM_WAIT: no effect.

Optional Feature:
- Macro: HALF_SWEEP_EN.
- Defined: the sweep for reference r issues addresses r..N only (Newton's-third-law half pairing). Particle r+1 still passes when r<N. The last sweep issues address N only.
- Undefined: every sweep issues 1..N. Total issued particle reads are N*N.

Test Plan:
- MEM_RD_LAT=1, count=3, no stall:
  - addr 0 issued the cycle after start.
  - reading_particle_num=1 one cycle later; ref_particle_count=3.
  - particle_id sequence 1,2,3 | 1,2,3 | 1,2,3 with ref_id 1,2,3 and phase 0,1,0.
  - prev_phase lags phase by 1 cycle; single done pulse.
- count=0: reading_particle_num pulse, then done, with no data_valid ever asserted; busy low afterwards.
- MEM_RD_LAT=3, count=4, stall high for 2 cycles mid-sweep 2:
  - data_valid shows a 2-cycle bubble; particle_id continues without loss or duplication.
  - Total data_valid cycles = 16.
- count=127:
  - last sweep ends at particle_id=127, ref_id=127, phase=0; no address wrap.
  - done asserted once.
- rst asserted during sweep 2 of count=5:
  - next cycle all outputs are at reset values and no done pulse.
  - a new start runs cleanly.
- HALF_SWEEP_EN defined, count=3: particle_id sequence 1,2,3 | 2,3 | 3; total data_valid cycles = 6.

Source files
------------

// File: rtl/home_broadcast_sequencer_if.sv
// Bundle for the home-cell read port and the broadcast sideband of home_broadcast_sequencer.
// fsm_state exposes the sequencer FSM encoding for observation only.
interface home_broadcast_sequencer_if #(
    parameter int PARTICLE_ID_WIDTH = 7
);
    // data_valid carries no ready: stall only withholds new reads, the pipeline
    // keeps moving, and every data_valid beat must be consumed in that cycle.
    logic                         start;
    logic                         stall;
    logic [PARTICLE_ID_WIDTH-1:0] rd_count;
    logic                         rd_en;
    logic [PARTICLE_ID_WIDTH-1:0] rd_addr;
    logic                         data_valid;
    logic [PARTICLE_ID_WIDTH-1:0] particle_id;
    logic [PARTICLE_ID_WIDTH-1:0] ref_id;
    logic                         phase;
    logic                         prev_phase;
    logic                         reading_particle_num;
    logic [PARTICLE_ID_WIDTH-1:0] ref_particle_count;
    logic                         busy;
    logic                         done;
    logic [2:0]                   fsm_state;

    modport master (
        input  start, stall, rd_count,
        output rd_en, rd_addr, data_valid, particle_id, ref_id, phase, prev_phase,
               reading_particle_num, ref_particle_count, busy, done, fsm_state
    );

    modport slave (
        output start, stall, rd_count,
        input  rd_en, rd_addr, data_valid, particle_id, ref_id, phase, prev_phase,
               reading_particle_num, ref_particle_count, busy, done, fsm_state
    );
endinterface

// File: rtl/home_broadcast_sequencer.sv
// Sweeps home-cell memory once per reference particle and emits the latency-aligned sideband.
// Define HALF_SWEEP_EN to have the sweep for reference r start at address r.
module home_broadcast_sequencer #(
    parameter int PARTICLE_ID_WIDTH = 7,
    parameter int MEM_RD_LAT        = 1
) (
    input logic clk,
    input logic rst,
    home_broadcast_sequencer_if.master bus
);
    localparam int W  = PARTICLE_ID_WIDTH;
    localparam int SW = 2 * W + 3;
    // Stage layout: {num, valid, phase, ref[W], pid[W]}
    localparam logic [SW-1:0] DL_RST = {3'b000, W'(1), W'(0)};

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_NUM_WAIT = 3'd1,
        S_SWEEP    = 3'd2,
        S_SWITCH   = 3'd3,
        S_DRAIN    = 3'd4,
        S_FINISH   = 3'd5
    } state_t;

    state_t         state, state_nx;
    logic [W-1:0]   addr_q, addr_nx;
    logic [W-1:0]   ref_q, ref_nx;
    logic [W-1:0]   cnt_q, cnt_nx;
    logic           phase_q, phase_nx;
    logic           issue_num, issue_valid;
    logic [W-1:0]   issue_addr;
    logic [SW-1:0]  dl [MEM_RD_LAT];
    logic [SW-1:0]  dl_out;
    logic           dl_busy;
    logic           prev_phase_q;

    assign dl_out = dl[MEM_RD_LAT-1];

    always_comb begin
        dl_busy = 1'b0;
        for (int i = 0; i < MEM_RD_LAT; i++) dl_busy = dl_busy | dl[i][2*W+1];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= S_IDLE;
            addr_q       <= '0;
            ref_q        <= W'(1);
            cnt_q        <= '0;
            phase_q      <= 1'b0;
            prev_phase_q <= 1'b0;
            for (int i = 0; i < MEM_RD_LAT; i++) dl[i] <= DL_RST;
        end else begin
            state        <= state_nx;
            addr_q       <= addr_nx;
            ref_q        <= ref_nx;
            cnt_q        <= cnt_nx;
            phase_q      <= phase_nx;
            prev_phase_q <= dl_out[2*W];
            dl[0]        <= {issue_num, issue_valid, phase_q, ref_q, issue_addr};
            for (int i = 1; i < MEM_RD_LAT; i++) dl[i] <= dl[i-1];
        end
    end

    always_comb begin
        state_nx    = state;
        addr_nx     = addr_q;
        ref_nx      = ref_q;
        cnt_nx      = cnt_q;
        phase_nx    = phase_q;
        issue_num   = 1'b0;
        issue_valid = 1'b0;
        issue_addr  = '0;
        case (state)
            S_IDLE: begin
                if (bus.start) begin
                    issue_num = 1'b1;
                    state_nx  = S_NUM_WAIT;
                end
            end
            S_NUM_WAIT: begin
                // The count word is only trusted on the cycle its marker leaves the delay line.
                if (dl_out[2*W+2]) begin
                    cnt_nx = bus.rd_count;
                    if (bus.rd_count == '0) begin
                        state_nx = S_FINISH;
                    end else begin
                        ref_nx   = W'(1);
                        phase_nx = 1'b0;
                        addr_nx  = W'(1);
                        state_nx = S_SWEEP;
                    end
                end
            end
            S_SWEEP: begin
                if (!bus.stall) begin
                    issue_valid = 1'b1;
                    issue_addr  = addr_q;
                    if (addr_q == cnt_q) state_nx = S_SWITCH;
                    else                 addr_nx  = addr_q + 1'b1;
                end
            end
            S_SWITCH: begin
                if (ref_q == cnt_q) begin
                    state_nx = S_DRAIN;
                end else begin
                    ref_nx   = ref_q + 1'b1;
                    phase_nx = ~phase_q;
`ifdef HALF_SWEEP_EN
                    addr_nx  = ref_q + 1'b1;
`else
                    addr_nx  = W'(1);
`endif
                    state_nx = S_SWEEP;
                end
            end
            S_DRAIN: begin
                if (!dl_busy) state_nx = S_FINISH;
            end
            S_FINISH: state_nx = S_IDLE;
            default:  state_nx = S_IDLE;
        endcase
    end

    assign bus.rd_en                = issue_num | issue_valid;
    assign bus.rd_addr              = issue_addr;
    assign bus.data_valid           = dl_out[2*W+1];
    assign bus.phase                = dl_out[2*W];
    assign bus.ref_id               = dl_out[2*W-1:W];
    assign bus.particle_id          = dl_out[W-1:0];
    assign bus.reading_particle_num = dl_out[2*W+2];
    assign bus.prev_phase           = prev_phase_q;
    assign bus.ref_particle_count   = cnt_q;
    assign bus.busy                 = (state != S_IDLE) && (state != S_FINISH);
    assign bus.done                 = (state == S_FINISH);
    assign bus.fsm_state            = state;
endmodule
